iiitb_alu_sched: RTL and testbench
==================================

# iiitb_alu_sched

Round-robin scheduler that shares one combinational 8-bit ALU among NREQ requesters. It accepts operand/opcode transactions over valid/ready handshakes, drives the shared ALU from registered operands, and captures the result. It returns each result on a single response channel tagged with the requester index. It sits between the requesting engines and the ALU instance; the ALU itself is instantiated outside this block.

## Interface
- NREQ, 4: number of requesters (2..8)
- W, 8: operand/result width; must match the ALU
- IDW, 2: requester-id width, = clog2(NREQ)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*W  operand A, requester i at bits [i*W +: W]
- req_b  in  NREQ*W  operand B, same packing
- req_op  in  NREQ*3  opcode, requester i at bits [i*3 +: 3]
- alu_a, alu_b  out  W  registered operands to the ALU
- alu_op  out  3  registered opcode to the ALU
- alu_r  in  W  ALU result (combinational from alu_a/alu_b/alu_op)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  index of the requester owning the response
- rsp_data  out  W  captured ALU result
- rsp_zero  out  1  rsp_data == 0
- busy  out  1  high in EXEC and RESP

## Operation
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - grant g = first i with req_valid[i], scanning ptr, ptr+1, ... mod NREQ.
  - req_ready[g] = 1 combinationally; all other req_ready bits are 0.
  - On handshake, register req_a[g], req_b[g] and req_op[g] into alu_a, alu_b, alu_op; register g into rsp_id; go to EXEC.
  - With no req_valid, stay in IDLE with req_ready = 0.
- EXEC: rsp_data <= alu_r; rsp_zero <= (alu_r == 0); go to RESP. req_ready = 0.
- RESP:
  - rsp_valid = 1; req_ready = 0.
  - On rsp_ready: ptr <= (rsp_id + 1) mod NREQ; go to IDLE.
  - rsp_valid, rsp_id, rsp_data and rsp_zero hold stable until accepted; there is no timeout.
- alu_a, alu_b and alu_op hold their last values outside the capture edge.
- Opcodes are not interpreted by this block. The ALU encoding is 0 add, 1 sub, 2 ~A, 3 nand, 4 nor, 5 and, 6 or, 7 xor; results are modulo 2^W.
- Requesters must hold valid and payload stable until ready. Deasserting valid before ready removes the requester from arbitration with no side effect.

## Timing
- Reset values, asynchronously on rst_n low:
  - state = IDLE, ptr = 0.
  - alu_a, alu_b, alu_op, rsp_id, rsp_data = 0.
  - rsp_zero, rsp_valid, busy = 0.
  - req_ready is low while rst_n is low.
- Latency: request accepted at edge N; result captured at edge N+1; rsp_valid is high from edge N+2.
- Throughput: with rsp_ready held high, one transaction per 3 cycles; the next accept is at edge N+3.
- Fairness: after requester k is served, k has lowest priority. With all requesters continuously valid, grants rotate 0,1,2,3,0,...
- Simultaneous events:
  - A request raised during EXEC/RESP waits for IDLE.
  - rsp_ready low in RESP stalls the block indefinitely.
  - ptr wraps from NREQ-1 to 0.
- Reset asserted mid-transaction aborts it. No response is produced; after release the block is in IDLE with ptr = 0.

## Test plan
- Single request: requester 2, A=0x7F, B=0x01, op=0 with the ALU model attached and rsp_ready=1 -> req_ready[2] at the accept cycle; rsp_valid 2 cycles later with rsp_id=2, rsp_data=0x80, rsp_zero=0.
- Wrap and zero flag: requester 0, A=0x05, B=0x05, op=1 -> rsp_data=0x00, rsp_zero=1. Then A=0x00, B=0x01, op=1 -> rsp_data=0xFF.
- Round robin: all 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1; accepts every 3 cycles; each rsp_id matches its requester's expected xor/and result.
- Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_id and rsp_data stable; req_ready=0 throughout; on rsp_ready=1, IDLE and the next grant follow.
- Priority rotation: serve requester 1, then assert 0 and 3 together -> 3 is granted before 0.
- Reset mid-op: assert rst_n=0 during EXEC -> all outputs go to reset values immediately; no rsp_valid after release; the next single request from requester 1 completes normally.

Source files
------------

// File: rtl/iiitb_alu_sched.sv
// iiitb_alu_sched: round-robin scheduler that shares one external combinational ALU
// among NREQ requesters. It accepts one request, registers its operands onto the
// ALU bus, captures the result one cycle later and returns it tagged with the
// requester id.
module iiitb_alu_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [2:0]        alu_op,
  input  logic [W-1:0]      alu_r,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_zero,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [IDW-1:0]      ptr_r;
  logic [IDW-1:0]      grant_s;
  logic                found_s;
  logic                accept_s;
  logic                rsp_done_s;
  logic [NREQ-1:0]     req_ready_s;
  logic [W-1:0]        alu_a_r;
  logic [W-1:0]        alu_b_r;
  logic [2:0]          alu_op_r;
  logic [IDW-1:0]      rsp_id_r;
  logic [W-1:0]        rsp_data_r;
  logic                rsp_zero_r;
  logic                rsp_valid_r;
  logic                busy_r;

  // Round-robin search: first valid requester starting at ptr and wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    grant_s = '0;
    found_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_r) + k) % NREQ;
      if (!found_s && req_valid[idx]) begin
        found_s = 1'b1;
        grant_s = IDW'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_EXEC;
        else          state_nxt_s = ST_IDLE;
      end
      ST_EXEC: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_RESP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: one-hot ready toward the granted requester, handshake strobes.
  always_comb begin
    req_ready_s = '0;
    accept_s    = 1'b0;
    rsp_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s && rst_n) begin
          accept_s    = 1'b1;
          req_ready_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_s;
        end else begin
          accept_s    = 1'b0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) rsp_done_s = 1'b1;
        else           rsp_done_s = 1'b0;
      end
      default: begin
        accept_s   = 1'b0;
        rsp_done_s = 1'b0;
      end
    endcase
  end

  // Operand capture on accept, result capture in EXEC; both hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_r    <= '0;
      alu_b_r    <= '0;
      alu_op_r   <= 3'd0;
      rsp_id_r   <= '0;
      rsp_data_r <= '0;
      rsp_zero_r <= 1'b0;
    end else if (accept_s) begin
      alu_a_r  <= req_a[int'(grant_s)*W +: W];
      alu_b_r  <= req_b[int'(grant_s)*W +: W];
      alu_op_r <= req_op[int'(grant_s)*3 +: 3];
      rsp_id_r <= grant_s;
    end else if (state_r == ST_EXEC) begin
      rsp_data_r <= alu_r;
      rsp_zero_r <= (alu_r == {W{1'b0}});
    end else begin
      rsp_data_r <= rsp_data_r;
    end
  end

  // Registered status flags: busy spans EXEC+RESP, rsp_valid spans RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else if (accept_s) begin
      busy_r      <= 1'b1;
    end else if (state_r == ST_EXEC) begin
      rsp_valid_r <= 1'b1;
    end else if (rsp_done_s) begin
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      busy_r      <= busy_r;
    end
  end

  // Priority pointer: the requester just served drops to lowest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (rsp_done_s) begin
      ptr_r <= (rsp_id_r == IDW'(NREQ-1)) ? {IDW{1'b0}} : rsp_id_r + {{(IDW-1){1'b0}}, 1'b1};
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign req_ready = req_ready_s;
  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_op    = alu_op_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_zero  = rsp_zero_r;
  assign rsp_valid = rsp_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_iiitb_alu_sched.sv
// Self-checking bench for iiitb_alu_sched: reference ALU attached to the ALU bus,
// expected responses queued at stimulus time and checked when the response
// handshake happens.
module tb_iiitb_alu_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [11:0] req_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic [7:0]  alu_r;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_zero;
  logic        busy;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  iiitb_alu_sched #(.NREQ(4), .W(8), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .busy(busy)
  );

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return ~a;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return a & b;
      3'd6:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Reference ALU on the shared bus.
  always_comb alu_r = alu_f(alu_a, alu_b, alu_op);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter for latency / throughput checks.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Scoreboard: compare each accepted response with the head of the queue.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
        check("rsp_zero", 32'(rsp_zero), 32'(mon_e.data == 8'h00));
      end
    end
  end

  task automatic raise(input int id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    exp_t e;
    req_a[id*8 +: 8]  = a;
    req_b[id*8 +: 8]  = b;
    req_op[id*3 +: 3] = op;
    req_valid[id]     = 1'b1;
    e.id   = 2'(id);
    e.data = alu_f(a, b, op);
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for a grant, check it targets id, drop valid after the accept edge.
  task automatic wait_accept(input int id, output int acc_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == 4'b0000 && n < 30);
    check("grant", 32'(req_ready), 32'(4'b0001 << id));
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int last;
    int rel;
    int n;
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_a     = 32'h0;
    req_b     = 32'h0;
    req_op    = 12'h0;
    rsp_ready = 1'b1;

    // Reset values, including ready held low despite valid requests.
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    req_valid = 4'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single request from requester 2: 0x7F + 0x01, latency check.
    raise(2, 8'h7F, 8'h01, 3'd0);
    wait_accept(2, acc);
    @(negedge clk);
    check("lat_busy_exec", 32'(busy), 32'd1);
    check("lat_valid_exec", 32'(rsp_valid), 32'd0);
    check("lat_alu_a", 32'(alu_a), 32'h7F);
    @(negedge clk);
    check("lat_valid_resp", 32'(rsp_valid), 32'd1);
    drain();

    // Zero flag and subtraction wrap on requester 0.
    raise(0, 8'h05, 8'h05, 3'd1);
    wait_accept(0, acc);
    drain();
    raise(0, 8'h00, 8'h01, 3'd1);
    wait_accept(0, acc);
    drain();

    // Serve requester 3 so the pointer wraps to 0.
    raise(3, 8'hA5, 8'h0F, 3'd7);
    wait_accept(3, acc);
    drain();

    // Round robin with all four continuously valid: 0,1,2,3,0,1 every 3 cycles.
    raise(0, 8'hF0, 8'h0F, 3'd7);
    raise(1, 8'hF0, 8'h3C, 3'd5);
    raise(2, 8'hAA, 8'hAA, 3'd7);
    raise(3, 8'hFF, 8'h81, 3'd5);
    exp_q.push_back('{id: 2'd0, data: 8'hFF});
    exp_q.push_back('{id: 2'd1, data: 8'h30});
    last = 0;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (req_ready == 4'b0000 && n < 30);
      check("rr_grant", 32'(req_ready), 32'(4'b0001 << (i % 4)));
      if (i > 0) check("rr_gap", 32'(cyc - last), 32'd3);
      last = cyc;
    end
    @(posedge clk);
    #1;
    req_valid = 4'h0;
    drain();

    // Backpressure: stall 10 cycles in RESP, late request from requester 2.
    rsp_ready = 1'b0;
    raise(1, 8'hC3, 8'h3C, 3'd6);
    wait_accept(1, acc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 30);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_data", 32'(rsp_data), 32'hFF);
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      if (i == 3) raise(2, 8'h12, 8'h34, 3'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    rel = cyc;
    wait_accept(2, acc);
    check("bp_next_grant", 32'(acc - rel), 32'd1);
    drain();

    // Priority rotation: after serving 1, requester 3 beats requester 0.
    raise(1, 8'h0F, 8'hF0, 3'd4);
    wait_accept(1, acc);
    drain();
    raise(3, 8'h55, 8'h00, 3'd2);
    raise(0, 8'h81, 8'h7F, 3'd3);
    wait_accept(3, acc);
    wait_accept(0, acc);
    drain();

    // Reset during EXEC aborts the transaction.
    raise(0, 8'h11, 8'h22, 3'd0);
    wait_accept(0, acc);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_alu_a", 32'(alu_a), 32'd0);
    check("mid_rst_alu_b", 32'(alu_b), 32'd0);
    check("mid_rst_alu_op", 32'(alu_op), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(rsp_valid), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    @(posedge clk);
    #1;
    raise(1, 8'h40, 8'h40, 3'd0);
    wait_accept(1, acc);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
